pipelined_shifter: RTL and testbench
====================================

// Module: pipelined_shifter
// PURPOSE
//  Pipelined, parametrised barrel shifter for the EX stage: SLL/SRL/SRA and variable forms SLLV/SRLV/SRAV.
//  Uses one log-shifter stage per shift-amount bit, each stage registered; valid/ready handshake on both sides.
//  Right shifts are bit-reversed into a single left-shift datapath and reversed back at the output stage.
// PARAMETERS
//  WIDTH   32  data width; power of 2, 8..64; LEVELS = log2(WIDTH) (localparam)
//  SAT_EN  1   1: inShift >= WIDTH saturates (0 for SLL/SRL, sign fill for SRA); 0: only inShift[LEVELS-1:0] used (MIPS)
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       synchronous reset, active-high
//  in_valid   in   1       operand beat valid
//  in_ready   out  1       block accepts beat this cycle
//  in         in   WIDTH   value to shift
//  inShift    in   32      shift amount (shamt or rs, zero-extended)
//  Signal     in   6       MIPS funct: 000000 SLL, 000010 SRL, 000011 SRA, 000100 SLLV, 000110 SRLV, 000111 SRAV
//  out_valid  out  1       result valid
//  out_ready  in   1       consumer takes result
//  out        out  WIDTH   shift result
//  bad_op     out  1       result belongs to an unsupported funct (qualified by out_valid)
// BEHAVIOUR
//  - Reset (rst=1 at clk edge): all stage valids, out_valid, out and bad_op = 0; in_ready = 1 in the cycle after. Beats in flight are dropped.
//  - advance = !out_valid | out_ready; in_ready = advance (combinational). Whole pipe moves together; no bubble squeeze.
//  - Accept when in_valid & in_ready. Stage 0 captures the operand, normalised op (L/R, arith) and effective amount.
//  - Latency: exactly LEVELS cycles from accept to out_valid when out_ready stays high (WIDTH=32 -> 5). Throughput 1/clk.
//  - Stage k (k=0..LEVELS-1) shifts by 2^k if amount bit k = 1; vacated bits get fill (0, or sign of the original in[WIDTH-1] for SRA).
//  - Right ops: operand bit-reversed at entry, result bit-reversed at exit; fill handled identically.
//  - SLL/SRL/SRA and the V forms use the same amount source (inShift); the decoder supplies the correct one.
//  - Amount: SAT_EN=1 and inShift >= WIDTH -> out = {WIDTH{fill}}; otherwise amount = inShift[LEVELS-1:0].
//  - Unsupported Signal: beat still traverses the pipe; out = 0, bad_op = 1.
//  - Stall: while out_valid & !out_ready, every stage register, out and bad_op hold.
//  - The in_ready drop caused by a stall is visible in the same cycle; upstream must hold in_valid and its data.
//  - in_valid=0 with advance=1 inserts a bubble (stage valid 0); a bubble never raises out_valid.
//  - Amount 0: out = in for all ops. Amount WIDTH-1 with SRA: out = all sign bits.
//  - Simultaneous accept and output handshake in one cycle: both take effect; no beat is lost or duplicated.
//  - rst overrides in-flight handshakes in the same cycle.
// TESTING
//  1 WIDTH=32: SLL in=0x0000_0001 inShift=31 -> out=0x8000_0000 exactly 5 clk after accept; bad_op=0.
//  2 SRA in=0x8000_00F0 inShift=4 -> 0xF800_000F; SRL same -> 0x0800_000F; SRAV inShift=40 with SAT_EN=1 -> 0xFFFF_FFFF.
//  3 SAT_EN=0: SLLV in=0x1 inShift=33 -> out=0x2; SAT_EN=1 same -> 0x0.
//  4 Back-to-back 8 beats with out_ready low for cycles 3-6 -> out order preserved, no loss, in_ready low exactly while stalled and full.
//  5 Signal=6'b100000 in=0x1234 -> out_valid after 5 clk, out=0, bad_op=1.
//  6 rst asserted with 3 beats in flight -> next cycle out_valid=0, out=0, in_ready=1; no stale beat emerges later.
//  Plus a random stimulus scoreboard against a behavioural model, WIDTH in {8,32,64}.

Source files
------------

// File: rtl/pipelined_shifter.sv
// pipelined_shifter
//   Pipelined barrel shifter for the EX stage. Supports SLL/SRL/SRA and the
//   variable forms SLLV/SRLV/SRAV. There is one registered log-shifter stage
//   per shift-amount bit. Right shifts are bit-reversed at entry, so one
//   left-shift datapath serves every op. The result is reversed back before
//   the last stage register.
//
// Parameters
//   WIDTH   data width, power of two in 8..64 (LEVELS = log2(WIDTH) stages)
//   SAT_EN  1: an amount >= WIDTH saturates to all-fill
//           0: only the low LEVELS bits of the amount are used
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous reset, active-high
//   in_valid   operand beat valid
//   in_ready   beat accepted this cycle (combinational from the output side)
//   in         value to shift
//   inShift    shift amount (shamt or rs, zero-extended)
//   Signal     MIPS funct code selecting the operation
//   out_valid  result valid
//   out_ready  consumer takes result
//   out        shift result
//   bad_op     result belongs to an unsupported funct (qualified by out_valid)

module pipelined_shifter #(
  parameter int WIDTH  = 32,
  parameter bit SAT_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in,
  input  logic [31:0]      inShift,
  input  logic [5:0]       Signal,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             bad_op
);

  localparam int LEVELS = $clog2(WIDTH);

  function automatic logic [WIDTH-1:0] bitrev(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) begin
      r[i] = v[WIDTH-1-i];
    end
    return r;
  endfunction

  // Entry decode and normalisation
  logic              op_ok;
  logic              op_right;
  logic              op_arith;
  logic              sat;
  logic              entry_fill;
  logic [WIDTH-1:0]  entry_data;
  logic [LEVELS-1:0] entry_amt;

  always_comb begin
    // Legal functs are 0,2,3,4,6,7. Bit 2 only separates the V forms, and
    // those take their amount from inShift just like the immediate forms.
    op_ok      = (Signal[5:3] == 3'b000) && (Signal[1:0] != 2'b01);
    op_right   = Signal[1];
    op_arith   = Signal[1] & Signal[0];
    entry_fill = op_ok & op_arith & in[WIDTH-1];
    sat        = SAT_EN && (inShift >= 32'(WIDTH));
    entry_amt  = inShift[LEVELS-1:0];
    entry_data = op_right ? bitrev(in) : in;
    if (!op_ok) begin
      // Unsupported op travels as a zero beat with no shifting.
      entry_data = '0;
      entry_amt  = '0;
    end else if (sat) begin
      // Saturated result is all fill, which is symmetric under reversal.
      entry_data = {WIDTH{entry_fill}};
      entry_amt  = '0;
    end
  end

  // Stage registers
  logic [WIDTH-1:0]  data_q [LEVELS];
  logic [WIDTH-1:0]  data_d [LEVELS];
  logic [LEVELS-1:0] amt_q  [LEVELS];
  logic [LEVELS-1:0] amt_d  [LEVELS];
  logic [LEVELS-1:0] valid_q, valid_d;
  logic [LEVELS-1:0] fill_q, fill_d;
  logic [LEVELS-1:0] right_q, right_d;
  logic [LEVELS-1:0] bad_q, bad_d;
  logic [LEVELS-1:0] unused_amt;
  logic              advance;

  // The whole pipe moves as one unit. It freezes only when the output holds
  // a beat that the consumer does not take.
  assign advance = !valid_q[LEVELS-1] || out_ready;

  genvar gi;
  generate
    for (gi = 0; gi < LEVELS; gi++) begin : g_stage
      localparam int SH = 1 << gi;
      localparam logic [WIDTH-1:0] LOW_MASK = {WIDTH{1'b1}} >> (WIDTH - SH);

      logic [WIDTH-1:0]  src_data;
      logic [WIDTH-1:0]  shifted;
      logic [LEVELS-1:0] src_amt;
      logic              src_valid;
      logic              src_fill;
      logic              src_right;
      logic              src_bad;

      if (gi == 0) begin : g_src
        assign src_data  = entry_data;
        assign src_amt   = entry_amt;
        assign src_valid = in_valid;
        assign src_fill  = entry_fill;
        assign src_right = op_ok & op_right;
        assign src_bad   = !op_ok;
      end else begin : g_src
        assign src_data  = data_q[gi-1];
        assign src_amt   = amt_q[gi-1];
        assign src_valid = valid_q[gi-1];
        assign src_fill  = fill_q[gi-1];
        assign src_right = right_q[gi-1];
        assign src_bad   = bad_q[gi-1];
      end

      // Vacated low bits take the fill value. For a reversed right shift,
      // these are the vacated high bits of the original operand.
      assign shifted = src_amt[gi]
                     ? ((src_data << SH) | (src_fill ? LOW_MASK : '0))
                     : src_data;

      if (gi == LEVELS - 1) begin : g_last
        assign data_d[gi] = src_right ? bitrev(shifted) : shifted;
      end else begin : g_mid
        assign data_d[gi] = shifted;
      end

      assign amt_d[gi]      = src_amt;
      assign valid_d[gi]    = src_valid;
      assign fill_d[gi]     = src_fill;
      assign right_d[gi]    = src_right;
      assign bad_d[gi]      = src_bad;
      assign unused_amt[gi] = ^amt_q[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      fill_q  <= '0;
      right_q <= '0;
      bad_q   <= '0;
      for (int k = 0; k < LEVELS; k++) begin
        data_q[k] <= '0;
        amt_q[k]  <= '0;
      end
    end else if (advance) begin
      valid_q <= valid_d;
      fill_q  <= fill_d;
      right_q <= right_d;
      bad_q   <= bad_d;
      for (int k = 0; k < LEVELS; k++) begin
        data_q[k] <= data_d[k];
        amt_q[k]  <= amt_d[k];
      end
    end
  end

  assign in_ready  = advance;
  assign out_valid = valid_q[LEVELS-1];
  assign out       = data_q[LEVELS-1];
  assign bad_op    = bad_q[LEVELS-1];

  // The last stage has already consumed its amount, fill and direction bits.
  logic unused_bits;
  assign unused_bits = ^{unused_amt, fill_q[LEVELS-1], right_q[LEVELS-1], Signal[2]};

endmodule

// File: tb/tb_pipelined_shifter.sv
module tb_pipelined_shifter;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [63:0] in64;
  logic [31:0] sh;
  logic [5:0]  sig;
  logic [3:0]  inr;
  logic [3:0]  outv;
  logic [3:0]  badv;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic [7:0]  out_c;
  logic [63:0] out_d;

  int n_cmp = 0;
  int n_err = 0;

  typedef logic [64:0] ent_t;
  ent_t expq [4][$];

  always #5 clk = ~clk;

  // k0: W32 saturating, k1: W32 masked, k2: W8 masked, k3: W64 saturating
  pipelined_shifter #(.WIDTH(32), .SAT_EN(1'b1)) u_s32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(inr[0]), .in(in64[31:0]),
    .inShift(sh), .Signal(sig), .out_valid(outv[0]), .out_ready(out_ready),
    .out(out_a), .bad_op(badv[0]));
  pipelined_shifter #(.WIDTH(32), .SAT_EN(1'b0)) u_m32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(inr[1]), .in(in64[31:0]),
    .inShift(sh), .Signal(sig), .out_valid(outv[1]), .out_ready(out_ready),
    .out(out_b), .bad_op(badv[1]));
  pipelined_shifter #(.WIDTH(8), .SAT_EN(1'b0)) u_m8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(inr[2]), .in(in64[7:0]),
    .inShift(sh), .Signal(sig), .out_valid(outv[2]), .out_ready(out_ready),
    .out(out_c), .bad_op(badv[2]));
  pipelined_shifter #(.WIDTH(64), .SAT_EN(1'b1)) u_s64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(inr[3]), .in(in64),
    .inShift(sh), .Signal(sig), .out_valid(outv[3]), .out_ready(out_ready),
    .out(out_d), .bad_op(badv[3]));

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Behavioural reference: plain shift operators, returns {bad, result}
  function automatic ent_t model(input int w, input bit sat_en, input logic [63:0] v,
                                 input logic [31:0] amount, input logic [5:0] f);
    logic [63:0] mask;
    logic [63:0] x;
    logic [63:0] r;
    bit ok, right, arith, sign;
    int a;
    mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    x = v & mask;
    ok = (f == 6'd0) || (f == 6'd2) || (f == 6'd3) || (f == 6'd4) || (f == 6'd6) || (f == 6'd7);
    if (!ok) return {1'b1, 64'd0};
    right = (f == 6'd2) || (f == 6'd3) || (f == 6'd6) || (f == 6'd7);
    arith = (f == 6'd3) || (f == 6'd7);
    sign  = x[w-1];
    if (sat_en && (amount >= 32'(w))) begin
      r = (arith && sign) ? mask : 64'd0;
    end else begin
      a = int'(amount % 32'(w));
      if (!right) begin
        r = (x << a) & mask;
      end else begin
        r = x >> a;
        if (arith && sign) r = r | (mask & ~(mask >> a));
      end
    end
    return {1'b0, r};
  endfunction

  function automatic ent_t got_of(input int k);
    ent_t g;
    case (k)
      0:       g = {badv[0], 32'd0, out_a};
      1:       g = {badv[1], 32'd0, out_b};
      2:       g = {badv[2], 56'd0, out_c};
      default: g = {badv[3], out_d};
    endcase
    return g;
  endfunction

  function automatic int wof(input int k);
    return (k == 2) ? 8 : ((k == 3) ? 64 : 32);
  endfunction

  function automatic bit satof(input int k);
    return !((k == 1) || (k == 2));
  endfunction

  // Scoreboard for all four instances; handshakes sampled mid-cycle
  always @(negedge clk) begin : mon
    ent_t e;
    if (rst) begin
      for (int k = 0; k < 4; k++) expq[k].delete();
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (outv[k] && out_ready) begin
          n_cmp++;
          if (expq[k].size() == 0) begin
            n_err++;
            $display("FAIL mon%0d_extra_beat: got %h required no beat", k, got_of(k));
          end else begin
            e = expq[k].pop_front();
            if (got_of(k) !== e) begin
              n_err++;
              $display("FAIL mon%0d_result: got %h required %h", k, got_of(k), e);
            end
          end
        end
        if (in_valid && inr[k]) expq[k].push_back(model(wof(k), satof(k), in64, sh, sig));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic [5:0]  sig;
    logic [31:0] din;
    logic [31:0] sh;
    logic [31:0] exp_sat;
    logic [31:0] exp_nosat;
    logic        bad;
  } vec_t;

  localparam int NV = 18;
  vec_t vt [NV];
  logic [5:0] ops [8];

  initial begin
    int lat;
    int acc;
    int got;
    int stale;
    logic [31:0] beat_exp;

    vt[0]  = '{6'd0,  32'h0000_0001, 32'd31,         32'h8000_0000, 32'h8000_0000, 1'b0};
    vt[1]  = '{6'd3,  32'h8000_00F0, 32'd4,          32'hF800_000F, 32'hF800_000F, 1'b0};
    vt[2]  = '{6'd2,  32'h8000_00F0, 32'd4,          32'h0800_000F, 32'h0800_000F, 1'b0};
    vt[3]  = '{6'd7,  32'h8000_00F0, 32'd40,         32'hFFFF_FFFF, 32'hFF80_0000, 1'b0};
    vt[4]  = '{6'd4,  32'h0000_0001, 32'd33,         32'h0000_0000, 32'h0000_0002, 1'b0};
    vt[5]  = '{6'h20, 32'h0000_1234, 32'd0,          32'h0000_0000, 32'h0000_0000, 1'b1};
    vt[6]  = '{6'd3,  32'h8000_0001, 32'd0,          32'h8000_0001, 32'h8000_0001, 1'b0};
    vt[7]  = '{6'd0,  32'h1234_5678, 32'd0,          32'h1234_5678, 32'h1234_5678, 1'b0};
    vt[8]  = '{6'd3,  32'h8000_0000, 32'd31,         32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0};
    vt[9]  = '{6'd7,  32'h7FFF_FFFF, 32'd31,         32'h0000_0000, 32'h0000_0000, 1'b0};
    vt[10] = '{6'd6,  32'hFFFF_FFFF, 32'd32,         32'h0000_0000, 32'hFFFF_FFFF, 1'b0};
    vt[11] = '{6'd4,  32'hDEAD_BEEF, 32'd8,          32'hADBE_EF00, 32'hADBE_EF00, 1'b0};
    vt[12] = '{6'd6,  32'hDEAD_BEEF, 32'd16,         32'h0000_DEAD, 32'h0000_DEAD, 1'b0};
    vt[13] = '{6'd7,  32'hDEAD_BEEF, 32'd16,         32'hFFFF_DEAD, 32'hFFFF_DEAD, 1'b0};
    vt[14] = '{6'd1,  32'h0000_FFFF, 32'd3,          32'h0000_0000, 32'h0000_0000, 1'b1};
    vt[15] = '{6'd3,  32'h4000_0000, 32'd32,         32'h0000_0000, 32'h4000_0000, 1'b0};
    vt[16] = '{6'd2,  32'h8000_0000, 32'd31,         32'h0000_0001, 32'h0000_0001, 1'b0};
    vt[17] = '{6'd3,  32'h8000_0000, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0};

    ops[0] = 6'd0; ops[1] = 6'd2; ops[2] = 6'd3; ops[3] = 6'd4;
    ops[4] = 6'd6; ops[5] = 6'd7; ops[6] = 6'd1; ops[7] = 6'h20;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in64 = '0; sh = '0; sig = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_valid_ready", {outv, inr}, {4'b0000, 4'b1111});
    chk("reset_out_bad", {out_a, badv}, {32'd0, 4'b0000});

    // Directed table: one beat at a time, latency and result on both W32 variants
    for (int i = 0; i < NV; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in64 = {32'd0, vt[i].din}; sh = vt[i].sh; sig = vt[i].sig;
      @(negedge clk);
      chk($sformatf("vec%0d_in_ready", i), inr[0], 1'b1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      for (int c = 1; c <= 12 && lat == 0; c++) begin
        @(negedge clk);
        if (outv[0]) lat = c;
      end
      chk($sformatf("vec%0d_latency", i), lat, 5);
      chk($sformatf("vec%0d_sat", i), {badv[0], out_a}, {vt[i].bad, vt[i].exp_sat});
      chk($sformatf("vec%0d_nosat", i), {outv[1], badv[1], out_b}, {1'b1, vt[i].bad, vt[i].exp_nosat});
    end
    @(posedge clk); #1;

    // Eight back-to-back beats with the consumer stalling in cycles 6..9
    acc = 0; got = 0;
    for (int n = 0; n < 40 && got < 8; n++) begin
      out_ready = !(n >= 6 && n <= 9);
      in_valid  = (acc < 8);
      if (acc < 8) begin
        in64 = 64'(acc + 1); sh = 32'(acc); sig = 6'd0;
      end
      @(negedge clk);
      if (n <= 11) chk($sformatf("stall_in_ready_c%0d", n), inr[0], !(n >= 6 && n <= 9));
      if (n >= 6 && n <= 9) chk($sformatf("stall_hold_c%0d", n), {outv[0], out_a}, {1'b1, 32'd4});
      if (in_valid && inr[0]) acc++;
      if (outv[0] && out_ready) begin
        beat_exp = 32'(got + 1) << got;
        chk($sformatf("stall_order_b%0d", got), out_a, beat_exp);
        got++;
      end
      @(posedge clk); #1;
    end
    chk("stall_beats_out", got, 8);
    chk("stall_beats_in", acc, 8);
    in_valid = 1'b0; out_ready = 1'b1;

    // Reset with beats in flight, including a handshake in the reset cycle
    for (int n = 0; n < 3; n++) begin
      in_valid = 1'b1; in64 = 64'(n + 5); sh = 32'd1; sig = 6'd0;
      @(posedge clk); #1;
    end
    rst = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("rst_valid_ready", {outv, inr}, {4'b0000, 4'b1111});
    chk("rst_out_bad", {out_a, badv}, {32'd0, 4'b0000});
    stale = 0;
    repeat (12) begin
      @(negedge clk);
      if (outv[0]) stale++;
    end
    chk("rst_no_stale", stale, 0);

    // Random traffic with random back-pressure, checked by the scoreboard
    for (int n = 0; n < 800; n++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in64 = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0:       sh = 32'($urandom_range(0, 7));
        1:       sh = 32'($urandom_range(0, 63));
        2:       sh = 32'($urandom_range(0, 70));
        default: sh = $urandom;
      endcase
      sig = ops[$urandom_range(0, 7)];
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 4; k++) chk($sformatf("drain_q%0d", k), expq[k].size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
